// File: rtl/mux_arbiter_nto1.sv
// mux_arbiter_nto1: N-to-1 multiplexer with a one-entry registered, handshaked output.
// Fixed mode grants the channel named by Selector. With the ROUND_ROBIN_EN macro
// defined, Mode=1 selects round-robin arbitration that starts after the last grant.
// Without ROUND_ROBIN_EN, Mode is ignored and the selection is always fixed.
module mux_arbiter_nto1 #(
  parameter int unsigned NBits     = 32,
  parameter int unsigned NChannels = 4,
  localparam int unsigned SelBits  = $clog2(NChannels)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Mode,
  input  logic [SelBits-1:0]           Selector,
  input  logic [NChannels-1:0]         In_Valid,
  input  logic [NChannels*NBits-1:0]   In_Data,
  output logic [NChannels-1:0]         In_Ready,
  output logic                         Out_Valid,
  output logic [NBits-1:0]             Out_Data,
  output logic [SelBits-1:0]           Out_Channel,
  input  logic                         Out_Ready
);

  logic               space;
  logic               grant_valid;
  logic [SelBits-1:0] grant;
  logic               accept;

`ifdef ROUND_ROBIN_EN
  logic [SelBits-1:0] rr_ptr;
`else
  logic unused_mode;
  assign unused_mode = Mode;
`endif

  assign space  = ~Out_Valid | Out_Ready;
  assign accept = grant_valid & space & ~reset;

  // Pick the granting channel for this cycle (fixed select or round-robin search).
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
`ifdef ROUND_ROBIN_EN
    if (Mode) begin
      logic [SelBits-1:0] idx;
      idx = '0;
      // Offsets 1..NChannels visit every real channel once, ending on rr_ptr itself.
      for (int unsigned i = 1; i <= NChannels; i++) begin
        idx = SelBits'((32'(rr_ptr) + i) % NChannels);
        if (!grant_valid && In_Valid[idx]) begin
          grant_valid = 1'b1;
          grant       = idx;
        end
      end
    end else
`endif
    if ((32'(Selector) < NChannels) && In_Valid[Selector]) begin
      grant_valid = 1'b1;
      grant       = Selector;
    end
  end

  // One-hot accept strobe back to the granted producer.
  always_comb begin
    In_Ready = '0;
    if (accept) begin
      In_Ready[grant] = 1'b1;
    end
  end

  // Output register: load on accept, drop valid when consumed with nothing new.
  always_ff @(posedge clk) begin
    if (reset) begin
      Out_Valid   <= 1'b0;
      Out_Data    <= '0;
      Out_Channel <= '0;
    end else if (accept) begin
      Out_Valid   <= 1'b1;
      Out_Data    <= In_Data[32'(grant)*NBits +: NBits];
      Out_Channel <= grant;
    end else if (Out_Ready) begin
      Out_Valid   <= 1'b0;
    end
  end

`ifdef ROUND_ROBIN_EN
  // Remember the last round-robin grant; reset value gives channel 0 first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= SelBits'(NChannels - 1);
    end else if (accept && Mode) begin
      rr_ptr <= grant;
    end
  end
`endif

endmodule
